// File: rtl/servo_waypoint_seq.sv
// servo_waypoint_seq: steps the slew block through a table of (angle, speed, dwell) waypoints.
// Define SERVO_WAYPOINT_SEQ_TIMEOUT_EN to add a MOVE timeout counter and a FAULT state.
module servo_waypoint_seq #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int DWELL_W   = 16,
    parameter int MAX_ANGLE = 180,
    parameter int RST_ANGLE = 60,
    parameter int TIMEOUT_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_angle,
    input  logic [1:0]         wr_speed,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [ADDR_W:0]    num_pts,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         pos_in,
    output logic [7:0]         angle_out,
    output logic [1:0]         speed_out,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  cur_idx,
    output logic               fault
);
`ifdef SERVO_WAYPOINT_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, LOAD, MOVE, DWELL, DONE, FAULT} state_t;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = ~TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] to_cnt;
`else
    typedef enum logic [2:0] {IDLE, LOAD, MOVE, DWELL, DONE} state_t;
`endif
    localparam logic [7:0]      MAX_A   = 8'(MAX_ANGLE);
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
    state_t state, state_n;
    logic [7:0]         angle_mem [DEPTH];
    logic [1:0]         speed_mem [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];
    logic [ADDR_W-1:0]  last;
    logic [ADDR_W:0]    n_pts;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               arrive, rest, go, adv;
    // Table is deliberately unreset; a same-cycle LOAD read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            angle_mem[wr_addr] <= (wr_angle > MAX_A) ? MAX_A : wr_angle;
            speed_mem[wr_addr] <= wr_speed;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end
    always_comb begin
        arrive = pos_in == angle_out;
        n_pts = (num_pts == '0) ? (ADDR_W+1)'(1) : (num_pts > DEPTH_N) ? DEPTH_N : num_pts;
`ifdef SERVO_WAYPOINT_SEQ_TIMEOUT_EN
        rest = state inside {IDLE, DONE, FAULT};
`else
        rest = state inside {IDLE, DONE};
`endif
        go = rest && start && !stop;
        state_n = state;
        case (state)
            LOAD:    state_n = MOVE;
`ifdef SERVO_WAYPOINT_SEQ_TIMEOUT_EN
            MOVE:    state_n = arrive ? DWELL : (to_cnt == TO_LAST) ? FAULT : MOVE;
`else
            MOVE:    state_n = arrive ? DWELL : MOVE;
`endif
            DWELL:   state_n = (dwell_cnt != '0) ? DWELL : (cur_idx != last || loop) ? LOAD : DONE;
            default: state_n = go ? LOAD : state;
        endcase
        if (stop)
            state_n = IDLE;
        adv = state == DWELL && dwell_cnt == '0 && state_n == LOAD;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            angle_out <= 8'(RST_ANGLE);
            speed_out <= '0;
            cur_idx   <= '0;
            last      <= '0;
            dwell_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n inside {LOAD, MOVE, DWELL};
            done  <= state_n == DONE;
            if (go) begin
                cur_idx <= '0;
                last    <= ADDR_W'(n_pts - (ADDR_W+1)'(1));
            end else if (adv) begin
                cur_idx <= (cur_idx == last) ? '0 : cur_idx + ADDR_W'(1);
            end
            // A stop landing on LOAD keeps the slew target where it was.
            if (state == LOAD && !stop) begin
                angle_out <= angle_mem[cur_idx];
                speed_out <= speed_mem[cur_idx];
            end
            if (state == MOVE && arrive)
                dwell_cnt <= dwell_mem[cur_idx];
            else if (state == DWELL && dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
    end
`ifdef SERVO_WAYPOINT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            to_cnt <= (state == MOVE) ? to_cnt + TIMEOUT_W'(1) : '0;
            fault  <= state_n == FAULT;
        end
    end
`else
    logic unused_to;
    assign unused_to = ^TIMEOUT_W;
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_servo_waypoint_seq.sv
// tb_servo_waypoint_seq: stimulus pushes cycle-stamped expected outputs; a negedge monitor pops and compares.
module tb_servo_waypoint_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_angle = '0;
    logic [1:0]  wr_speed = '0;
    logic [15:0] wr_dwell = '0;
    logic [3:0]  num_pts = 4'd1;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        follow = 1'b0;
    logic [7:0]  pos_reg = 8'd60;
    logic [7:0]  pos_in, angle_out;
    logic [1:0]  speed_out;
    logic        busy, done, fault;
    logic [2:0]  cur_idx;
    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] a;
        logic [1:0] s;
        logic       b;
        logic       d;
        logic [2:0] i;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    servo_waypoint_seq dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_angle(wr_angle),
        .wr_speed(wr_speed), .wr_dwell(wr_dwell), .num_pts(num_pts), .loop(loop),
        .start(start), .stop(stop), .pos_in(pos_in), .angle_out(angle_out),
        .speed_out(speed_out), .busy(busy), .done(done), .cur_idx(cur_idx), .fault(fault)
    );

    // follow=1 models a slew block that reaches its target instantly
    assign pos_in = follow ? angle_out : pos_reg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc < cyc)
                $display("FAIL %s: expectation for cycle %0d never sampled", e.nm, e.cyc);
            else if ({angle_out, speed_out, busy, done, cur_idx, fault} !== {e.a, e.s, e.b, e.d, e.i, 1'b0})
                $display("FAIL %s @%0d: got angle=%0d speed=%0d busy=%0b done=%0b idx=%0d fault=%0b, want angle=%0d speed=%0d busy=%0b done=%0b idx=%0d fault=0",
                         e.nm, cyc, angle_out, speed_out, busy, done, cur_idx, fault, e.a, e.s, e.b, e.d, e.i);
            else
                n_pass++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic want(input int dc, input string nm, input int a, input int s, input int b, input int d, input int i);
        q.push_back('{cyc + dc, nm, 8'(a), 2'(s), 1'(b), 1'(d), 3'(i)});
    endtask

    task automatic wr(input int ad, input int an, input int sp, input int dw);
        wr_en = 1'b1;
        wr_addr = 3'(ad);
        wr_angle = 8'(an);
        wr_speed = 2'(sp);
        wr_dwell = 16'(dw);
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        step(2);
        rst = 1'b1;
        want(0, "reset", 60, 0, 0, 0, 0);
        step(1);
        // single point with a ramping position, start pulse while busy is ignored
        wr(0, 90, 2, 5);
        want(1, "A_load", 60, 0, 1, 0, 0);
        want(2, "A_move", 90, 2, 1, 0, 0);
        want(4, "A_ramp", 90, 2, 1, 0, 0);
        want(10, "A_dwell_end", 90, 2, 1, 0, 0);
        want(11, "A_done", 90, 2, 0, 1, 0);
        want(13, "A_done_hold", 90, 2, 0, 1, 0);
        start = 1'b1; step(1); start = 1'b0; step(1);
        pos_reg = 70; step(1);
        pos_reg = 80; step(1);
        pos_reg = 90; step(1);
        start = 1'b1; step(1); start = 1'b0; step(7);
        want(1, "B_stop_done", 90, 2, 0, 0, 0);
        stop = 1'b1; step(1); stop = 1'b0;
        // three points looping, stop on the second pass of entry 1
        wr(0, 30, 0, 0);
        wr(1, 150, 3, 2);
        wr(2, 0, 1, 0);
        num_pts = 4'd3; loop = 1'b1; follow = 1'b1;
        want(1, "C_load0", 90, 2, 1, 0, 0);
        want(2, "C_e0", 30, 0, 1, 0, 0);
        want(4, "C_load1", 30, 0, 1, 0, 1);
        want(5, "C_e1", 150, 3, 1, 0, 1);
        want(9, "C_load2", 150, 3, 1, 0, 2);
        want(10, "C_e2", 0, 1, 1, 0, 2);
        want(12, "C_wrap", 0, 1, 1, 0, 0);
        want(13, "C_e0_again", 30, 0, 1, 0, 0);
        want(16, "C_e1_again", 150, 3, 1, 0, 1);
        want(19, "C_stop", 150, 3, 0, 0, 1);
        want(21, "C_stop_hold", 150, 3, 0, 0, 1);
        start = 1'b1; step(1); start = 1'b0; step(17);
        stop = 1'b1; step(1); stop = 1'b0; step(2);
        // all 8 entries with num_pts=9, entry 4 written above MAX_ANGLE
        for (int i = 0; i < 8; i++) wr(i, (i == 4) ? 200 : 10 * i + 10, i % 4, 0);
        num_pts = 4'd9; loop = 1'b0;
        for (int i = 0; i < 8; i++) want(2 + 3 * i, $sformatf("D_entry%0d", i), (i == 4) ? 180 : 10 * i + 10, i % 4, 1, 0, i);
        want(25, "D_done", 80, 3, 0, 1, 7);
        start = 1'b1; step(1); start = 1'b0; step(25);
        // num_pts=0 runs entry 0 only; restart from DONE
        num_pts = 4'd0;
        want(1, "E_restart", 80, 3, 1, 0, 0);
        want(4, "E_done", 10, 0, 0, 1, 0);
        start = 1'b1; step(1); start = 1'b0; step(4);
        // target equals current position, dwell 0
        follow = 1'b0; pos_reg = 60; num_pts = 4'd1;
        wr(0, 60, 1, 0);
        want(1, "F_load", 10, 0, 1, 0, 0);
        want(2, "F_move", 60, 1, 1, 0, 0);
        want(3, "F_dwell", 60, 1, 1, 0, 0);
        want(4, "F_done", 60, 1, 0, 1, 0);
        start = 1'b1; step(1); start = 1'b0; step(4);
        // stop beats start in the same cycle
        want(1, "G_stop", 60, 1, 0, 0, 0);
        want(2, "G_start_stop", 60, 1, 0, 0, 0);
        want(3, "G_stay_idle", 60, 1, 0, 0, 0);
        stop = 1'b1; step(1); start = 1'b1; step(1); start = 1'b0; stop = 1'b0; step(2);
        // write during LOAD uses old entry; looping single entry; stop mid-MOVE holds target
        wr(0, 70, 3, 0);
        pos_reg = 70; loop = 1'b1;
        want(2, "H_old_entry", 70, 3, 1, 0, 0);
        want(5, "H_new_entry", 100, 2, 1, 0, 0);
        want(8, "H_stuck", 100, 2, 1, 0, 0);
        want(9, "H_stop_move", 100, 2, 0, 0, 0);
        start = 1'b1; step(1); start = 1'b0;
        wr(0, 100, 2, 0);
        step(6);
        stop = 1'b1; step(1); stop = 1'b0;
        // asynchronous reset mid-MOVE
        loop = 1'b0;
        want(2, "I_move", 100, 2, 1, 0, 0);
        start = 1'b1; step(1); start = 1'b0; step(2);
        rst = 1'b0;
        want(0, "I_async_rst", 60, 0, 0, 0, 0);
        want(1, "I_rst_held", 60, 0, 0, 0, 0);
        step(2);
        rst = 1'b1; step(1);
        // long stall in MOVE: no timeout without the optional feature
        wr(0, 100, 2, 0);
        want(2, "J_move", 100, 2, 1, 0, 0);
        want(1002, "J_no_fault", 100, 2, 1, 0, 0);
        start = 1'b1; step(1); start = 1'b0; step(1001);
        want(1, "J_stop", 100, 2, 0, 0, 0);
        stop = 1'b1; step(1); stop = 1'b0; step(2);
        while (q.size() > 0) begin
            $display("FAIL %s: expectation for cycle %0d left unchecked", q[0].nm, q[0].cyc);
            void'(q.pop_front());
            n_chk++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/servo_waypoint_seq.md
Name: servo_waypoint_seq

Overview:
Waypoint sequencer for the servo angle-slew block. It holds a small table of (angle, speed, dwell) entries and drives the slew block's target angle and speed inputs one entry at a time. For each entry it waits until the slew block's output position reaches the target, then holds for the programmed dwell before advancing. It sits between the host/register interface and the slew block, and it is the only driver of that block's angle/speed inputs.

Parameters:
DEPTH, 8, number of waypoint entries (power of 2)
ADDR_W, 3, log2(DEPTH)
DWELL_W, 16, dwell counter width in clk cycles
MAX_ANGLE, 180, upper clamp applied to written angles
RST_ANGLE, 60, angle_out reset value (equals the slew block's reset position)
TIMEOUT_W, 24, MOVE timeout counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  entry index to write
wr_angle  in  8  target angle for the entry; values >MAX_ANGLE are stored as MAX_ANGLE
wr_speed  in  2  slew speed code for the entry
wr_dwell  in  DWELL_W  hold time after arrival, in cycles
num_pts  in  ADDR_W+1  active entries 1..DEPTH; 0 is treated as 1; values >DEPTH are treated as DEPTH; sampled on start
loop  in  1  1 = wrap to entry 0 after the last entry; sampled every time the last entry completes
start  in  1  begin the sequence at entry 0
stop  in  1  abort the sequence
pos_in  in  8  current position from the slew block's out_angle
angle_out  out  8  target angle to the slew block
speed_out  out  2  speed code to the slew block
busy  out  1  high in LOAD, MOVE and DWELL
done  out  1  high in DONE
cur_idx  out  ADDR_W  entry currently being executed
fault  out  1  MOVE timeout flag (optional feature only)

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; angle_out=RST_ANGLE, speed_out=0, cur_idx=0, busy=0, done=0, fault=0.
  - Table contents are undefined after reset; the table itself is not reset.
- Table writes:
  - Accepted in any state; the written entry is readable the next cycle.
  - A write to the entry being read in LOAD that same cycle does not affect that LOAD; LOAD uses the old value.
- Registered outputs: all outputs are registered and update one cycle after the state or condition that changes them.
- IDLE:
  - busy=0; angle_out and speed_out hold their last values.
  - start=1 -> cur_idx=0, latch last=clamped num_pts-1, go to LOAD.
- LOAD (1 cycle): angle_out<=angle[cur_idx], speed_out<=speed[cur_idx], go to MOVE.
- MOVE:
  - Compare begins the first MOVE cycle, using the newly loaded angle_out.
  - pos_in==angle_out -> dwell_cnt<=dwell[cur_idx], go to DWELL.
  - An entry whose angle equals the current position therefore spends exactly 1 cycle in MOVE.
- DWELL:
  - dwell_cnt decrements by 1 per cycle; exit on the cycle dwell_cnt==0.
  - dwell=0 -> 1 cycle in DWELL; dwell=N -> N+1 cycles.
  - On exit, with cur_idx!=last: cur_idx+1, go to LOAD.
  - On exit, with cur_idx==last and loop=1: cur_idx=0, go to LOAD.
  - On exit, with cur_idx==last and loop=0: go to DONE.
- DONE:
  - done=1, busy=0; outputs hold.
  - start -> same as start from IDLE (done clears the next cycle).
  - stop -> IDLE.
- start while busy: ignored.
- stop: from any state, go to IDLE next cycle. angle_out and speed_out hold, so the slew block finishes its current move. done=0, fault=0. stop has priority over start in the same cycle.
- Async reset mid-sequence: returns immediately to reset values. The slew block resets in parallel to the same position.
- Width rules:
  - cur_idx wraps modulo DEPTH only through the loop path; it never exceeds last.
  - dwell_cnt does not underflow.

Optional Feature:
Macro SERVO_WAYPOINT_SEQ_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entering MOVE and increments each MOVE cycle.
  - If it saturates at all-ones before arrival, go to FAULT: fault=1, busy=0, outputs hold.
  - FAULT exits only on stop (to IDLE) or start (restart at entry 0, fault clears).
- Not defined: no counter and no FAULT state; fault is tied to 0 and MOVE waits indefinitely.

Test Plan:
- Reset: pulse rst low mid-cycle -> angle_out=60, speed_out=0, busy=0, done=0 immediately.
- Single point, num_pts=1, loop=0, entry0=(90,speed 2,dwell 5): start; model pos_in ramping from 60 -> angle_out=90 two cycles after start; DONE entered exactly 6 cycles after pos_in==90 is first sampled in MOVE; done=1.
- Three points (30,0,0)(150,3,2)(0,1,0), loop=1: cur_idx sequence 0,1,2,0; angle_out 30,150,0,30; stop during the second pass of entry1 -> IDLE next cycle, angle_out holds 150.
- Write wr_angle=200 to entry 4 -> reads back and drives 180. num_pts=0 -> runs entry 0 only. num_pts=9 -> runs 8 entries.
- Target equals current position (60), dwell 0: MOVE 1 cycle, DWELL 1 cycle. Start in the same cycle as stop -> stays IDLE. Start while busy -> no restart.
- With SERVO_WAYPOINT_SEQ_TIMEOUT_EN, TIMEOUT_W=4, pos_in stuck at 60, target 90 -> fault=1 after 15 MOVE cycles, busy=0; start clears fault and restarts at entry 0. Without the macro, fault stays 0 over 1000 cycles.
